// File: rtl/ppu_scroll_regs.sv
// PPU "t" scroll/address latch with the shared $2005/$2006 write toggle.
// CPU register writes are ignored until a post-reset warm-up count expires.
module ppu_scroll_regs #(
    parameter int unsigned WARMUP_CYCLES = 16,
    parameter int unsigned WARMUP_W      = 16
) (
    input  logic       PCLK,
    input  logic       n_RES,
    input  logic [2:0] RS,
    input  logic       WR,
    input  logic       RD,
    input  logic [7:0] CPU_DB,
    output logic [2:0] FH,
    output logic [2:0] FV,
    output logic [4:0] TV,
    output logic [4:0] TH,
    output logic       NTV,
    output logic       NTH,
    output logic       W6_2_Ena,
    output logic       TGL,
    output logic       READY
);

    logic                wr_d;
    logic                rd_d;
    logic                wr_evt;
    logic                rd_evt;
    logic [WARMUP_W-1:0] warm_cnt;

    assign wr_evt = WR & ~wr_d;
    assign rd_evt = RD & ~rd_d;
    assign READY  = (warm_cnt == '0);

    always_ff @(posedge PCLK or negedge n_RES) begin
        if (!n_RES) begin
            wr_d     <= 1'b0;
            rd_d     <= 1'b0;
            warm_cnt <= WARMUP_W'(WARMUP_CYCLES);
            FH       <= '0;
            FV       <= '0;
            TV       <= '0;
            TH       <= '0;
            NTV      <= 1'b0;
            NTH      <= 1'b0;
            TGL      <= 1'b0;
            W6_2_Ena <= 1'b0;
        end else begin
            wr_d     <= WR;
            rd_d     <= RD;
            W6_2_Ena <= 1'b0;

            if (warm_cnt != '0)
                warm_cnt <= warm_cnt - WARMUP_W'(1);

            // $2002 read clears the toggle even while writes are still blocked
            if (rd_evt && RS == 3'd2)
                TGL <= 1'b0;

            if (wr_evt && READY) begin
                case (RS)
                    3'd0: begin
                        NTH <= CPU_DB[0];
                        NTV <= CPU_DB[1];
                    end
                    3'd5: begin
                        if (!TGL) begin
                            TH <= CPU_DB[7:3];
                            FH <= CPU_DB[2:0];
                        end else begin
                            TV <= CPU_DB[7:3];
                            FV <= CPU_DB[2:0];
                        end
                        TGL <= ~TGL;
                    end
                    3'd6: begin
                        if (!TGL) begin
                            FV      <= {1'b0, CPU_DB[5:4]};
                            NTV     <= CPU_DB[3];
                            NTH     <= CPU_DB[2];
                            TV[4:3] <= CPU_DB[1:0];
                        end else begin
                            TV[2:0]  <= CPU_DB[7:5];
                            TH       <= CPU_DB[4:0];
                            W6_2_Ena <= 1'b1;
                        end
                        TGL <= ~TGL;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
